stopwatch_counter: RTL and testbench
====================================

// Module: stopwatch_counter
// PURPOSE
//  BCD stopwatch that produces the four time digits (SS.hh, 00.00..99.99) consumed by the display selector in endless mode.
//  Divides clk down to a 1/100 s tick, runs a 4-digit BCD carry chain, and accepts start/stop/clear pulses from the game FSM.
//  All outputs are registered. Reset is asynchronous, active-low.
// PARAMETERS
//  TICK_DIV  1000000  clk cycles per 1/100 s tick (100 MHz clk -> 10 ms); must be >= 2
//  DIV_W     20       prescaler width; 2**DIV_W > TICK_DIV-1
// PORTS
//  clk          in   1  system clock, all logic on posedge
//  rst_n        in   1  asynchronous active-low reset
//  level        in   2  game mode; counting allowed only when level == `state_endless
//  start        in   1  1-cycle pulse: begin/resume counting
//  stop         in   1  1-cycle pulse: pause counting
//  clear        in   1  1-cycle pulse: zero digits, return to IDLE
//  sec_ten      out  4  seconds tens digit, BCD 0..9
//  sec_uni      out  4  seconds units digit, BCD 0..9
//  msec_ten     out  4  tenths-of-second digit, BCD 0..9
//  msec_uni     out  4  hundredths-of-second digit, BCD 0..9
//  running      out  1  1 while in RUN
//  max_reached  out  1  1 while in FULL (99.99 held)
// BEHAVIOUR
//  Reset: state=IDLE, all digits 0, prescaler 0, running=0, max_reached=0.
//  States: IDLE (00.00, halted), RUN (counting), PAUSE (halted, value held), FULL (99.99, halted).
//  Priority per cycle: clear > stop/level-exit > start > tick.
//  clear (any state): next edge -> IDLE, digits 0, prescaler 0.
//  start in IDLE or PAUSE with level==`state_endless: next edge -> RUN; prescaler resumes from held value (0 after IDLE).
//  start while level!=`state_endless: ignored. start in RUN or FULL: ignored.
//  stop in RUN: next edge -> PAUSE; prescaler and digits hold. stop in other states: ignored.
//  level leaves `state_endless while RUN: next edge -> PAUSE (same as stop).
//  RUN prescaler: counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps to 0 and on that same edge the digits advance by 00.01.
//  Tick on same cycle as stop or clear: increment suppressed.
//  BCD carry: msec_uni 9->0 carries to msec_ten; msec_ten 9->0 to sec_uni; sec_uni 9->0 to sec_ten. No digit ever exceeds 9.
//  Increment that produces 99.99: digits = 99.99 and state -> FULL on that edge; max_reached=1, running=0 from then on.
//  FULL: digits held at 99.99, no wrap; start/stop ignored; only clear exits.
//  running = (state==RUN); max_reached = (state==FULL); both registered with state.
//  Latency: start sampled at edge n -> running=1 after edge n; first increment at edge n+TICK_DIV (from IDLE).
//  Reset asserted mid-count: immediate return to reset values regardless of clk.
// TESTING (sim with TICK_DIV=4)
//  1 rst_n low, then high, no pulses for 20 cycles -> digits 00.00, running=0, max_reached=0.
//  2 level=endless, start pulse, run 40 cycles -> digits 00.10, running=1; increments every 4 cycles.
//  3 from 00.09 one tick -> 00.10; from 09.99 one tick -> 10.00; from 99.98 one tick -> 99.99, max_reached=1, holds 100 cycles; start ignored.
//  4 stop on the cycle the prescaler is at 3 -> no increment, PAUSE, value held; start -> resumes, next increment after 1 cycle.
//  5 RUN, then level changes to a non-endless mode -> PAUSE after one edge; start with level non-endless -> stays PAUSE.
//  6 clear+stop+start in same cycle during RUN -> IDLE at 00.00; rst_n pulse low mid-count -> digits 0 asynchronously.

Source files
------------

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: BCD stopwatch SS.hh (00.00..99.99) for endless mode.
// Prescaled 1/100 s tick, 4-digit BCD carry chain, start/stop/clear control.
//
// Ports:
//   clk          system clock, posedge
//   rst_n        asynchronous active-low reset
//   level [1:0]  game mode; counting only when level == `STATE_ENDLESS
//   start        pulse: begin/resume counting from IDLE or PAUSE
//   stop         pulse: pause counting while in RUN
//   clear        pulse: zero digits and prescaler, go to IDLE
//   sec_ten      seconds tens digit (BCD)
//   sec_uni      seconds units digit (BCD)
//   msec_ten     tenths digit (BCD)
//   msec_uni     hundredths digit (BCD)
//   running      1 while in RUN
//   max_reached  1 while in FULL (99.99 held)

`ifndef STATE_ENDLESS
`define STATE_ENDLESS 2'd3
`endif

module stopwatch_counter #(
    parameter int TICK_DIV = 1000000,
    parameter int DIV_W    = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] level,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] sec_ten,
    output logic [3:0] sec_uni,
    output logic [3:0] msec_ten,
    output logic [3:0] msec_uni,
    output logic       running,
    output logic       max_reached
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_FULL
    } state_t;

    localparam logic [DIV_W-1:0] PRE_MAX =
        DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] PRE_ONE =
        DIV_W'(1);

    state_t           state;
    state_t           state_nx;
    logic [DIV_W-1:0] pre;
    logic [DIV_W-1:0] pre_nx;
    logic [3:0]       d3_nx;
    logic [3:0]       d2_nx;
    logic [3:0]       d1_nx;
    logic [3:0]       d0_nx;

    logic       endless;
    logic       tick;
    logic       c0;
    logic       c1;
    logic       c2;
    logic [3:0] i0;
    logic [3:0] i1;
    logic [3:0] i2;
    logic [3:0] i3;
    logic       last_step;

    assign endless = (level == `STATE_ENDLESS);
    assign tick    = (pre == PRE_MAX);

    // BCD ripple: each digit wraps 9->0 and carries upward.
    assign c0 = (msec_uni == 4'd9);
    assign c1 = c0 && (msec_ten == 4'd9);
    assign c2 = c1 && (sec_uni == 4'd9);

    assign i0 = c0 ? 4'd0 : msec_uni + 4'd1;
    assign i1 = c0 ? (msec_ten == 4'd9 ? 4'd0
                                       : msec_ten + 4'd1)
                   : msec_ten;
    assign i2 = c1 ? (sec_uni == 4'd9 ? 4'd0
                                      : sec_uni + 4'd1)
                   : sec_uni;
    assign i3 = c2 ? (sec_ten == 4'd9 ? 4'd0
                                      : sec_ten + 4'd1)
                   : sec_ten;

    // The increment from 99.98 lands on 99.99 and freezes there.
    assign last_step = ({sec_ten, sec_uni,
                         msec_ten, msec_uni} == 16'h9998);

    always_comb begin
        state_nx = state;
        pre_nx   = pre;
        d3_nx    = sec_ten;
        d2_nx    = sec_uni;
        d1_nx    = msec_ten;
        d0_nx    = msec_uni;

        if (clear) begin
            state_nx = S_IDLE;
            pre_nx   = '0;
            d3_nx    = 4'd0;
            d2_nx    = 4'd0;
            d1_nx    = 4'd0;
            d0_nx    = 4'd0;
        end else begin
            unique case (state)
                S_RUN: begin
                    if (stop || !endless) begin
                        state_nx = S_PAUSE;
                    end else if (tick) begin
                        pre_nx = '0;
                        d3_nx  = i3;
                        d2_nx  = i2;
                        d1_nx  = i1;
                        d0_nx  = i0;
                        if (last_step) begin
                            state_nx = S_FULL;
                        end
                    end else begin
                        pre_nx = pre + PRE_ONE;
                    end
                end
                S_IDLE, S_PAUSE: begin
                    if (start && endless) begin
                        state_nx = S_RUN;
                    end
                end
                S_FULL: begin
                    state_nx = S_FULL;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pre         <= '0;
            sec_ten     <= 4'd0;
            sec_uni     <= 4'd0;
            msec_ten    <= 4'd0;
            msec_uni    <= 4'd0;
            running     <= 1'b0;
            max_reached <= 1'b0;
        end else begin
            state       <= state_nx;
            pre         <= pre_nx;
            sec_ten     <= d3_nx;
            sec_uni     <= d2_nx;
            msec_ten    <= d1_nx;
            msec_uni    <= d0_nx;
            running     <= (state_nx == S_RUN);
            max_reached <= (state_nx == S_FULL);
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed bench for stopwatch_counter.
// Runs with TICK_DIV=4; inputs change and outputs sample on negedge.

`ifndef STATE_ENDLESS
`define STATE_ENDLESS 2'd3
`endif

module tb_stopwatch_counter;

    logic       clk;
    logic       rst_n;
    logic [1:0] level;
    logic       start;
    logic       stop;
    logic       clear;
    logic [3:0] sec_ten;
    logic [3:0] sec_uni;
    logic [3:0] msec_ten;
    logic [3:0] msec_uni;
    logic       running;
    logic       max_reached;

    int total;
    int bad;

    stopwatch_counter #(
        .TICK_DIV(4),
        .DIV_W   (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .level      (level),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .sec_ten    (sec_ten),
        .sec_uni    (sec_uni),
        .msec_ten   (msec_ten),
        .msec_uni   (msec_uni),
        .running    (running),
        .max_reached(max_reached)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h",
                     tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] dig();
        return {sec_ten, sec_uni, msec_ten, msec_uni};
    endfunction

    task automatic chk_st(input string tag,
                          input logic [15:0] d,
                          input logic r,
                          input logic m);
        chk({tag, ".dig"}, dig(), d);
        chk({tag, ".run"}, 16'(running), 16'(r));
        chk({tag, ".max"}, 16'(max_reached), 16'(m));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        level = 2'd0;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;

        // 1: reset and idle
        step(2);
        chk_st("rst", 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(20);
        chk_st("idle", 16'h0000, 1'b0, 1'b0);

        // 2/3: run from 00.00 up to FULL
        level = `STATE_ENDLESS;
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk_st("go", 16'h0000, 1'b1, 1'b0);
        step(39);
        chk("c39", dig(), 16'h0009);
        step(1);
        chk_st("c40", 16'h0010, 1'b1, 1'b0);
        step(3959);
        chk("c3999", dig(), 16'h0999);
        step(1);
        chk("c4000", dig(), 16'h1000);
        step(35995);
        chk_st("c39995", 16'h9998, 1'b1, 1'b0);
        step(1);
        chk_st("full", 16'h9999, 1'b0, 1'b1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b1;
        step(1);
        stop  = 1'b0;
        step(100);
        chk_st("hold", 16'h9999, 1'b0, 1'b1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk_st("clr", 16'h0000, 1'b0, 1'b0);

        // 4: stop when prescaler at 3
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk_st("stop3", 16'h0000, 1'b0, 1'b0);
        step(10);
        chk("paused", dig(), 16'h0000);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk_st("resume", 16'h0000, 1'b1, 1'b0);
        step(1);
        chk("res+1", dig(), 16'h0001);

        // 5: level exit pauses; start ignored
        step(2);
        level = 2'd0;
        step(1);
        chk_st("lvl", 16'h0001, 1'b0, 1'b0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        chk_st("lvl_st", 16'h0001, 1'b0, 1'b0);

        // 6: clear wins, then async reset
        level = `STATE_ENDLESS;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(5);
        chk_st("rerun", 16'h0002, 1'b1, 1'b0);
        clear = 1'b1;
        stop  = 1'b1;
        start = 1'b1;
        step(1);
        clear = 1'b0;
        stop  = 1'b0;
        start = 1'b0;
        chk_st("csst", 16'h0000, 1'b0, 1'b0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(9);
        chk_st("c9", 16'h0002, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_st("arst", 16'h0000, 1'b0, 1'b0);
        step(1);
        rst_n = 1'b1;
        step(3);
        chk_st("post", 16'h0000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d",
                 total, bad);
        $finish;
    end

endmodule
